// File: rtl/cons_gen_pkg.sv
// Shared types and constants for the threshold-OR solution generator.
// Holds the FSM state type, LFSR geometry/taps, default seed and counter widths.
package cons_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_OFFER  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int          LFSR_W       = 16;
   // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int          CNT_W        = 16;
   localparam int          REJ_W        = 16;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/cons_thr_check.sv
// Combinational predicate: v satisfies the constraint when any bit at or above SHIFT is set.
module cons_thr_check #(
   parameter int WIDTH = 13,
   parameter int SHIFT = 9
) (
   input  logic [WIDTH-1:0] v,
   output logic             sat
);

   assign sat = |(v >> SHIFT);

endmodule

// File: rtl/cons_thr_solution_gen.sv
// Streams values satisfying |(v >> SHIFT), either in ascending order or drawn
// from a 16-bit Fibonacci LFSR with rejection of non-satisfying candidates.
module cons_thr_solution_gen
   import cons_gen_pkg::*;
#(
   parameter int          WIDTH = 13,
   parameter int          SHIFT = 9,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [15:0]      count_req,
   output logic             sol_valid,
   input  logic             sol_ready,
   output logic [WIDTH-1:0] sol_data,
   output logic             busy,
   output logic             done,
   output logic [15:0]      reject_cnt
);

   localparam logic [WIDTH-1:0] PTR_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PTR_BASE = PTR_ONE << SHIFT;
   localparam logic [WIDTH-1:0] PTR_MAX  = {WIDTH{1'b1}};

   state_e             state_q, state_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [WIDTH-1:0]   enum_ptr_q, enum_ptr_d;
   logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic [REJ_W-1:0]   reject_cnt_q, reject_cnt_d;
   logic [WIDTH-1:0]   sol_data_q, sol_data_d;
   logic               sol_valid_q, sol_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   candidate;
   logic               cand_sat;

   assign candidate = lfsr_q[WIDTH-1:0];

   cons_thr_check #(
      .WIDTH(WIDTH),
      .SHIFT(SHIFT)
   ) u_check (
      .v  (candidate),
      .sat(cand_sat)
   );

   // Next-state, datapath updates and registered-output targets.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      remaining_d  = remaining_q;
      enum_ptr_d   = enum_ptr_q;
      lfsr_d       = lfsr_q;
      reject_cnt_d = reject_cnt_q;
      sol_data_d   = sol_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d       = mode;
               remaining_d  = count_req;
               reject_cnt_d = {REJ_W{1'b0}};
               enum_ptr_d   = PTR_BASE;
               if (count_req == 16'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SEARCH;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            if (mode_q == 1'b0) begin
               sol_data_d = enum_ptr_q;
               state_d    = ST_OFFER;
            end else begin
               lfsr_d = lfsr_next(lfsr_q);
               if (cand_sat) begin
                  sol_data_d = candidate;
                  state_d    = ST_OFFER;
               end else begin
                  if (reject_cnt_q != 16'hFFFF) begin
                     reject_cnt_d = reject_cnt_q + 16'd1;
                  end else begin
                     reject_cnt_d = reject_cnt_q;
                  end
                  state_d = ST_SEARCH;
               end
            end
         end
         ST_OFFER: begin
            if (sol_ready) begin
               remaining_d = remaining_q - 16'd1;
               if (mode_q == 1'b0) begin
                  // wrap skips the non-satisfying range below 2**SHIFT
                  enum_ptr_d = (enum_ptr_q == PTR_MAX) ? PTR_BASE : (enum_ptr_q + PTR_ONE);
               end else begin
                  enum_ptr_d = enum_ptr_q;
               end
               if (remaining_q == 16'd1) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SEARCH;
               end
            end else begin
               state_d = ST_OFFER;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      sol_valid_d = (state_d == ST_OFFER);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= 1'b0;
         remaining_q  <= {CNT_W{1'b0}};
         enum_ptr_q   <= PTR_BASE;
         lfsr_q       <= SEED;
         reject_cnt_q <= {REJ_W{1'b0}};
         sol_data_q   <= {WIDTH{1'b0}};
         sol_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         remaining_q  <= remaining_d;
         enum_ptr_q   <= enum_ptr_d;
         lfsr_q       <= lfsr_d;
         reject_cnt_q <= reject_cnt_d;
         sol_data_q   <= sol_data_d;
         sol_valid_q  <= sol_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign sol_valid  = sol_valid_q;
   assign sol_data   = sol_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_cons_thr_solution_gen.sv
// Scoreboard bench for cons_thr_solution_gen: stimulus pushes expected solutions,
// a negedge monitor pops and compares on every accepted handshake.
module tb_cons_thr_solution_gen;

   localparam int          WIDTH = 13;
   localparam int          SHIFT = 9;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic             clk;
   logic             rst;
   logic             start;
   logic             mode;
   logic [15:0]      count_req;
   logic             sol_valid;
   logic             sol_ready;
   logic [WIDTH-1:0] sol_data;
   logic             busy;
   logic             done;
   logic [15:0]      reject_cnt;
   logic             pred_sat;

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               done_cnt = 0;
   int               accept_cyc = -1;
   int               run_start_cyc = 0;
   int               rdy_mode = 0;
   int               exp_rej = 0;
   logic [15:0]      lfsr_m;
   logic [WIDTH-1:0] exp_q[$];
   logic             prev_hold = 1'b0;
   logic             prev_done = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   cons_thr_solution_gen #(.WIDTH(WIDTH), .SHIFT(SHIFT), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .count_req(count_req),
      .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_data(sol_data),
      .busy(busy), .done(done), .reject_cnt(reject_cnt)
   );

   cons_thr_check #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_pred (.v(sol_data), .sat(pred_sat));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pops on handshake, hold/stability and done-pulse checks.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", {31'd0, sol_valid}, 32'd1);
            check("hold_data", {19'd0, sol_data}, {19'd0, prev_data});
         end
         if (sol_valid && sol_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sol", {19'd0, sol_data}, 32'hFFFF_FFFF);
            end else begin
               check("sol_data", {19'd0, sol_data}, {19'd0, exp_q.pop_front()});
            end
            check("sol_sat", {31'd0, pred_sat}, 32'd1);
            accept_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (accept_cyc > run_start_cyc) begin
               check("done_latency", cyc - accept_cyc, 32'd1);
            end
         end
         prev_hold = sol_valid && !sol_ready;
         prev_data = sol_data;
         prev_done = done;
      end
   end

   // Ready driver: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      sol_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       sol_ready = 1'($urandom_range(0, 1));
            2:       sol_ready = 1'b0;
            default: sol_ready = 1'b1;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lfsr_step();
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      lfsr_m = SEED;
   endtask

   task automatic push_enum(input int n);
      logic [WIDTH-1:0] ptr;
      ptr = 13'd512;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(ptr);
         if (ptr == 13'h1FFF) ptr = 13'd512;
         else ptr = ptr + 13'd1;
      end
   endtask

   task automatic push_rand(input int n);
      logic [WIDTH-1:0] c;
      exp_rej = 0;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 100000; k++) begin
            c = lfsr_m[WIDTH-1:0];
            lfsr_step();
            if (c >= 13'd512) begin
               exp_q.push_back(c);
               break;
            end
            exp_rej++;
         end
      end
      if (exp_rej > 65535) exp_rej = 65535;
   endtask

   task automatic pulse_start(input logic m, input logic [15:0] n);
      mode          = m;
      count_req     = n;
      start         = 1'b1;
      run_start_cyc = cyc;
      tick();
      start     = 1'b0;
      mode      = ~m;
      count_req = 16'h0005;
   endtask

   task automatic finish_run(input string nm, input int d0, input int budget, input logic chk_rej);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt > d0) break;
      end
      tick();
      tick();
      check({nm, "_done_cnt"}, done_cnt - d0, 32'd1);
      check({nm, "_queue_left"}, exp_q.size(), 32'd0);
      if (chk_rej) check({nm, "_reject_cnt"}, {16'd0, reject_cnt}, exp_rej);
   endtask

   task automatic wait_valid(input string nm);
      int seen;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sol_valid) begin
            seen = 1;
            break;
         end
      end
      check({nm, "_valid_seen"}, seen, 32'd1);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; mode = 1'b0; count_req = 16'd0;
      lfsr_m = SEED;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sol_valid", {31'd0, sol_valid}, 32'd0);
      check("rst_sol_data", {19'd0, sol_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_reject_cnt", {16'd0, reject_cnt}, 32'd0);
      #1 rst = 1'b0;
      tick();

      // Enumerate 3 with latency checks
      rdy_mode = 0;
      push_enum(3);
      d0 = done_cnt;
      pulse_start(1'b0, 16'd3);
      @(negedge clk);
      check("enum_lat_busy", {31'd0, busy}, 32'd1);
      check("enum_lat_valid0", {31'd0, sol_valid}, 32'd0);
      @(negedge clk);
      check("enum_lat_valid1", {31'd0, sol_valid}, 32'd1);
      check("enum_first", {19'd0, sol_data}, 32'd512);
      finish_run("enum3", d0, 100, 1'b1);

      // Random single after reset: seed low bits come out first
      do_reset();
      exp_q.push_back(13'h0CE1);
      lfsr_step();
      exp_rej = 0;
      d0 = done_cnt;
      pulse_start(1'b1, 16'd1);
      finish_run("rand1", d0, 100, 1'b1);

      // Backpressure: value held for 5 stalled cycles
      rdy_mode = 2;
      push_enum(2);
      d0 = done_cnt;
      pulse_start(1'b0, 16'd2);
      wait_valid("bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, sol_valid}, 32'd1);
         check("bp_data", {19'd0, sol_data}, 32'd512);
      end
      rdy_mode = 0;
      finish_run("bp", d0, 100, 1'b0);

      // Zero count: immediate done, no offer
      d0 = done_cnt;
      pulse_start(1'b0, 16'd0);
      @(negedge clk);
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_valid", {31'd0, sol_valid}, 32'd0);
      finish_run("zero", d0, 20, 1'b0);

      // Wrap-around: 7680th value is 8191, 7681st is 512
      push_enum(7681);
      check("wrap_model_last", {19'd0, exp_q[7680]}, 32'd512);
      d0 = done_cnt;
      pulse_start(1'b0, 16'd7681);
      finish_run("wrap", d0, 20000, 1'b0);

      // Start while busy is ignored
      rdy_mode = 2;
      push_enum(3);
      exp_rej = 0;
      d0 = done_cnt;
      pulse_start(1'b0, 16'd3);
      repeat (3) tick();
      mode = 1'b1; count_req = 16'd9; start = 1'b1;
      tick();
      start = 1'b0;
      rdy_mode = 0;
      finish_run("busy_start", d0, 100, 1'b1);
      repeat (5) tick();
      check("busy_start_idle", {31'd0, busy}, 32'd0);

      // Random soak with random ready
      do_reset();
      rdy_mode = 1;
      push_rand(1000);
      d0 = done_cnt;
      pulse_start(1'b1, 16'd1000);
      finish_run("soak", d0, 30000, 1'b1);

      // Reset during OFFER aborts with no done and reseeds the LFSR
      do_reset();
      rdy_mode = 2;
      push_rand(5);
      pulse_start(1'b1, 16'd5);
      wait_valid("abort");
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      lfsr_m = SEED;
      @(negedge clk);
      check("abort_valid", {31'd0, sol_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (4) tick();
      check("abort_no_done", done_cnt - d0, 32'd0);
      rdy_mode = 0;
      exp_q.push_back(13'h0CE1);
      lfsr_step();
      exp_rej = 0;
      d0 = done_cnt;
      pulse_start(1'b1, 16'd1);
      finish_run("restart", d0, 100, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cons_thr_solution_gen.md
Name: cons_thr_solution_gen

Overview:
Sequential solution generator for threshold-OR constraints of the form |(v >> SHIFT) on a WIDTH-bit variable. The existing constraint blocks check an assignment; this block produces assignments that satisfy the constraint.
Supports two modes: ordered enumeration, and LFSR-random with rejection.
Solutions stream out over a valid/ready handshake to downstream solver and verification logic.

Parameters:
WIDTH, 13, bit width of the solved variable
SHIFT, 9, constraint shift; v satisfies iff v >= 2**SHIFT (SHIFT < WIDTH)
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a generation run; sampled only in IDLE
mode  in  1  0 = enumerate, 1 = random; captured on start
count_req  in  16  number of solutions to emit; captured on start
sol_valid  out  1  sol_data holds a satisfying value
sol_ready  in  1  consumer accepts the value
sol_data  out  WIDTH  solution value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a run completes
reject_cnt  out  16  random-mode rejected candidates in the current run; saturates at 16'hFFFF

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: sol_valid=0, sol_data=0, busy=0, done=0, reject_cnt=0, lfsr=SEED, state=IDLE.
- Reset mid-run aborts the run immediately. No done pulse is issued and the LFSR reseeds.
- FSM states: IDLE, SEARCH, OFFER, DONE.
- IDLE, on start:
  - capture mode and count_req into remaining
  - clear reject_cnt
  - set enum_ptr = 2**SHIFT
  - if count_req == 0, go to DONE; otherwise go to SEARCH
- SEARCH, enumerate mode: sol_data <= enum_ptr, then go to OFFER. Every enum_ptr value is satisfying by construction.
- SEARCH, random mode:
  - candidate = lfsr[WIDTH-1:0]; lfsr advances every SEARCH cycle
  - if candidate satisfies, sol_data <= candidate and go to OFFER
  - otherwise increment reject_cnt (saturating) and stay in SEARCH
- OFFER:
  - sol_valid=1, and sol_data is held stable until the handshake
  - on sol_valid && sol_ready: remaining decrements; in enumerate mode enum_ptr increments
  - if remaining was 1, go to DONE; otherwise go to SEARCH
  - sol_valid deasserts the cycle after acceptance
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start to first sol_valid is 2 cycles in enumerate mode
  - in random mode it is 2 + rejects cycles
  - throughput is one solution per 2 cycles maximum
- Enumeration wrap-around: after enum_ptr reaches 2**WIDTH-1, the next value is 2**SHIFT, never 0.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - shift left; feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] enters bit 0
  - the LFSR is not reseeded on start, so consecutive runs continue the sequence
- start while busy is ignored, and mode/count_req changes during a run have no effect.
- Invariant: every accepted sol_data satisfies |(sol_data >> SHIFT).

Decomposition:
- Shared package cons_gen_pkg holds:
  - state enum type
  - LFSR width and tap constant
  - default SEED
  - count and reject counter widths
- One natural sub-module: cons_thr_check (combinational; in: v[WIDTH-1:0]; out: sat = |(v >> SHIFT)).
  - used for random-mode rejection
  - reused as the bench's scoreboard predicate

Test Plan:
- Enumerate run: rst, then start with mode=0, count_req=3, sol_ready=1 -> sol_data 512, 513, 514 in order; then done pulses once; reject_cnt=0.
- Random after reset: start with mode=1, count_req=1 -> first sol_data=13'h0CE1 (SEED low bits, satisfying); reject_cnt=0; done one cycle after acceptance.
- Backpressure: enumerate with count_req=2 and sol_ready held 0 for 5 cycles in OFFER -> sol_valid stays 1 and sol_data stays 512; on release, 513 follows.
- Wrap and zero count:
  - enumerate with count_req=7681 -> value 7680 is 8191 and value 7681 is 512
  - count_req=0 -> done pulses 1 cycle after start and sol_valid never asserts
- Random soak: count_req=1000 with random sol_ready -> every value >= 512 (checked with cons_thr_check); reject_cnt equals the SEARCH cycles with an unsatisfied candidate.
- Reset and start during a run:
  - assert rst during OFFER -> next cycle sol_valid=0, busy=0, no done pulse; after restart the first random value is again 13'h0CE1
  - start pulsed while busy -> ignored
